fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, default queue depth, queue entry layout.
package fetch_unit_pkg;

  localparam int unsigned QDEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } qentry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Instruction queue between fetch and IF/ID: power-of-two ring buffer with flush.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [31:0]               push_pc_i,
  input  logic [31:0]               push_inst_i,
  input  logic                      pop_i,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic                      valid_o,
  output logic [31:0]               head_pc_o,
  output logic [31:0]               head_inst_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  qentry_t          mem [QDEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign do_pop = pop_i && (count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem[wptr] <= '{pc: push_pc_i, inst: push_inst_i};
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign count_o     = count;
  assign valid_o     = (count != '0);
  assign head_pc_o   = valid_o ? mem[rptr].pc   : '0;
  assign head_inst_o = valid_o ? mem[rptr].inst : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding instruction-memory request FSM feeding fetch_queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        pc_adv_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [31:0]      addr_q;
  logic [31:0]      addr_nxt;
  logic             push;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Only one request is ever in flight, so gating on the current count alone
  // keeps occupancy plus outstanding within QDEPTH.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i && !flush_i && (count < CNT_W'(QDEPTH))) begin
          state_nxt = ST_REQ;
          addr_nxt  = pc_i;
        end
      end
      ST_REQ: begin
        if (imem_ack_i) begin
          state_nxt = ST_IDLE;
          push      = !flush_i;
        end else if (flush_i) begin
          state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_ack_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pc_adv_o    = push && !rst_i;
  assign imem_req_o  = (state != ST_IDLE);
  assign imem_addr_o = addr_q;

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (push),
    .push_pc_i   (addr_q),
    .push_inst_i (imem_data_i),
    .pop_i       (!id_stall_i),
    .count_o     (count),
    .valid_o     (inst_valid_o),
    .head_pc_o   (inst_pc_o),
    .head_inst_o (inst_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, random stream vs model.
module tb_fetch_unit;

  localparam int unsigned QD = 2;

  logic        clk = 1'b0;
  logic        rst_i, start_i, imem_ack_i, flush_i, id_stall_i;
  logic [31:0] pc_i, imem_data_i;
  logic        pc_adv_o, imem_req_o, inst_valid_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o;

  always #5 clk = ~clk;

  fetch_unit #(.QDEPTH(QD)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .pc_adv_o    (pc_adv_o),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .flush_i     (flush_i),
    .id_stall_i  (id_stall_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic f, input logic st,
                       input logic [31:0] pc, input logic [31:0] d);
    rst_i = r; start_i = s; imem_ack_i = a; flush_i = f; id_stall_i = st;
    pc_i = pc; imem_data_i = d;
  endtask

  typedef struct {
    logic        rst, start, ack, flush, stall;
    logic [31:0] pc, data;
    logic        req;
    logic [31:0] addr;
    logic        adv, valid;
    logic [31:0] inst, ipc;
  } vec_t;

  function automatic vec_t v(input logic r, input logic s, input logic a, input logic f, input logic st,
                             input logic [31:0] pc, input logic [31:0] d, input logic req,
                             input logic [31:0] addr, input logic adv, input logic valid,
                             input logic [31:0] inst, input logic [31:0] ipc);
    vec_t t;
    t.rst = r; t.start = s; t.ack = a; t.flush = f; t.stall = st; t.pc = pc; t.data = d;
    t.req = req; t.addr = addr; t.adv = adv; t.valid = valid; t.inst = inst; t.ipc = ipc;
    return t;
  endfunction

  vec_t        tbl [14];
  logic [31:0] mq [$];
  int          pops, pushes, wait_left, cyc;
  logic        adv;

  initial begin
    // Reset, single fetch with one wait cycle, then fill-to-depth under stall and drain in order.
    tbl[0]  = v(1,0,0,0,0, 32'h0, 32'h0,        0, 32'h0, 0, 0, 32'h0,        32'h0);
    tbl[1]  = v(0,1,0,0,0, 32'h0, 32'h0,        0, 32'h0, 0, 0, 32'h0,        32'h0);
    tbl[2]  = v(0,1,0,0,0, 32'h0, 32'h0,        1, 32'h0, 0, 0, 32'h0,        32'h0);
    tbl[3]  = v(0,1,1,0,0, 32'h0, 32'hAABBCCDD, 1, 32'h0, 1, 0, 32'h0,        32'h0);
    tbl[4]  = v(0,1,0,0,1, 32'h4, 32'h0,        0, 32'h0, 0, 1, 32'hAABBCCDD, 32'h0);
    tbl[5]  = v(0,1,1,0,1, 32'h4, 32'h11111111, 1, 32'h4, 1, 1, 32'hAABBCCDD, 32'h0);
    tbl[6]  = v(0,1,0,0,1, 32'h8, 32'h0,        0, 32'h4, 0, 1, 32'hAABBCCDD, 32'h0);
    tbl[7]  = v(0,1,0,0,1, 32'h8, 32'h0,        0, 32'h4, 0, 1, 32'hAABBCCDD, 32'h0);
    tbl[8]  = v(0,1,0,0,0, 32'h8, 32'h0,        0, 32'h4, 0, 1, 32'hAABBCCDD, 32'h0);
    tbl[9]  = v(0,1,0,0,1, 32'h8, 32'h0,        0, 32'h4, 0, 1, 32'h11111111, 32'h4);
    tbl[10] = v(0,0,1,0,1, 32'h8, 32'h22222222, 1, 32'h8, 1, 1, 32'h11111111, 32'h4);
    tbl[11] = v(0,0,0,0,0, 32'hC, 32'h0,        0, 32'h8, 0, 1, 32'h11111111, 32'h4);
    tbl[12] = v(0,0,0,0,0, 32'hC, 32'h0,        0, 32'h8, 0, 1, 32'h22222222, 32'h8);
    tbl[13] = v(0,0,0,0,0, 32'hC, 32'h0,        0, 32'h8, 0, 0, 32'h0,        32'h0);

    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    edge1();
    edge1();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].ack, tbl[i].flush, tbl[i].stall, tbl[i].pc, tbl[i].data);
      @(negedge clk);
      chk1($sformatf("tbl%0d.req", i),   imem_req_o,   tbl[i].req);
      chk ($sformatf("tbl%0d.addr", i),  imem_addr_o,  tbl[i].addr);
      chk1($sformatf("tbl%0d.adv", i),   pc_adv_o,     tbl[i].adv);
      chk1($sformatf("tbl%0d.valid", i), inst_valid_o, tbl[i].valid);
      chk ($sformatf("tbl%0d.inst", i),  inst_o,       tbl[i].inst);
      chk ($sformatf("tbl%0d.ipc", i),   inst_pc_o,    tbl[i].ipc);
      edge1();
    end

    // Flush while waiting for ack: late data must be dropped, refetch at the redirected pc.
    drive(0, 1, 0, 0, 0, 32'h100, 32'h0);
    @(negedge clk); chk1("fl.idle_req", imem_req_o, 1'b0);
    edge1();
    drive(0, 1, 0, 1, 0, 32'h100, 32'h0);
    @(negedge clk); chk1("fl.req", imem_req_o, 1'b1); chk("fl.addr", imem_addr_o, 32'h100);
    chk1("fl.adv0", pc_adv_o, 1'b0);
    edge1();
    drive(0, 1, 0, 0, 0, 32'h200, 32'h0);
    @(negedge clk); chk1("fl.discard_req", imem_req_o, 1'b1); chk1("fl.adv1", pc_adv_o, 1'b0);
    edge1();
    drive(0, 1, 1, 0, 0, 32'h200, 32'hDEAD0000);
    @(negedge clk); chk1("fl.late_ack_adv", pc_adv_o, 1'b0);
    edge1();
    drive(0, 1, 0, 0, 0, 32'h200, 32'h0);
    @(negedge clk); chk1("fl.valid", inst_valid_o, 1'b0); chk1("fl.req_after", imem_req_o, 1'b0);
    edge1();
    drive(0, 1, 1, 0, 1, 32'h200, 32'h12345678);
    @(negedge clk); chk1("fl.refetch_req", imem_req_o, 1'b1);
    chk("fl.refetch_addr", imem_addr_o, 32'h200); chk1("fl.refetch_adv", pc_adv_o, 1'b1);
    edge1();

    // Flush coinciding with ack and a pop: data dropped, queue empty next cycle.
    drive(0, 1, 0, 0, 1, 32'h204, 32'h0);
    @(negedge clk); chk1("fa.valid", inst_valid_o, 1'b1);
    chk("fa.inst", inst_o, 32'h12345678); chk("fa.ipc", inst_pc_o, 32'h200);
    edge1();
    drive(0, 1, 1, 1, 0, 32'h204, 32'hBEEF0000);
    @(negedge clk); chk1("fa.adv", pc_adv_o, 1'b0); chk1("fa.req", imem_req_o, 1'b1);
    edge1();
    drive(0, 0, 0, 0, 0, 32'h204, 32'h0);
    @(negedge clk); chk1("fa.valid_after", inst_valid_o, 1'b0);
    chk1("fa.req_after", imem_req_o, 1'b0); chk("fa.inst_after", inst_o, 32'h0);
    edge1();

    // No request may be issued in a flush cycle.
    drive(0, 1, 0, 1, 0, 32'h208, 32'h0);
    edge1();
    drive(0, 0, 0, 0, 0, 32'h208, 32'h0);
    @(negedge clk); chk1("nf.req", imem_req_o, 1'b0);
    edge1();

    // Reset mid-request; ack arriving afterwards is ignored.
    drive(0, 1, 0, 0, 0, 32'h300, 32'h0);
    edge1();
    drive(1, 1, 0, 0, 0, 32'h300, 32'h0);
    @(negedge clk); chk1("rs.req_before", imem_req_o, 1'b1); chk1("rs.adv", pc_adv_o, 1'b0);
    edge1();
    drive(0, 0, 1, 0, 0, 32'h300, 32'hCAFEF00D);
    @(negedge clk); chk1("rs.req", imem_req_o, 1'b0); chk1("rs.adv_late", pc_adv_o, 1'b0);
    chk1("rs.valid", inst_valid_o, 1'b0); chk("rs.addr", imem_addr_o, 32'h0);
    chk("rs.inst", inst_o, 32'h0); chk("rs.ipc", inst_pc_o, 32'h0);
    edge1();
    drive(0, 0, 0, 0, 0, 32'h300, 32'h0);
    @(negedge clk); chk1("rs.valid_after", inst_valid_o, 1'b0);
    edge1();

    // Random stream: 200 instructions must emerge at pc 0,4,8,... with matching data.
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    edge1();
    edge1();
    pops = 0; pushes = 0; wait_left = -1; cyc = 0;
    while (pops < 200 && cyc < 5000) begin
      drive(0, 1, 1'b0, 0, ($urandom_range(0, 2) == 0), pc_i, 32'h0);
      if (imem_req_o) begin
        if (wait_left < 0) wait_left = $urandom_range(0, 3);
        if (wait_left == 0) begin
          imem_ack_i  = 1'b1;
          imem_data_i = mem_word(imem_addr_o);
        end else begin
          wait_left--;
        end
      end
      @(negedge clk);
      chk1("rnd.valid", inst_valid_o, mq.size() != 0);
      chk1("rnd.adv", pc_adv_o, imem_ack_i);
      chk1("rnd.occupancy", (mq.size() + int'(imem_req_o)) <= QD, 1'b1);
      if (mq.size() != 0) begin
        chk("rnd.ipc", inst_pc_o, mq[0]);
        chk("rnd.inst", inst_o, mem_word(mq[0]));
        if (!id_stall_i) begin
          void'(mq.pop_front());
          pops++;
        end
      end
      if (imem_ack_i) begin
        mq.push_back(32'(pushes) * 32'd4);
        pushes++;
        wait_left = -1;
      end
      adv = pc_adv_o;
      edge1();
      if (adv) pc_i = pc_i + 32'd4;
      cyc++;
    end
    chk("rnd.delivered", 32'(pops), 32'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
